// File: rtl/mem_requester_pkg.sv
// Shared encodings for the shared-RAM requester: FSM states and Mem_Ctrl bit layout.
package mem_requester_pkg;

    localparam logic [1:0] MRQ_IDLE   = 2'd0;
    localparam logic [1:0] MRQ_REQ    = 2'd1;
    localparam logic [1:0] MRQ_RDWAIT = 2'd2;
    localparam logic [1:0] MRQ_FIN    = 2'd3;

    localparam int MC_RDEN = 0;
    localparam int MC_WREN = 1;

    // Exactly one of rden/wren is set; the upper two control bits are always 0.
    function automatic logic [3:0] mc_encode(input logic is_write);
        logic [3:0] mc;
        mc          = 4'b0000;
        mc[MC_RDEN] = ~is_write;
        mc[MC_WREN] = is_write;
        return mc;
    endfunction

endpackage

// File: rtl/mem_requester_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (rst || clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_requester.sv
// Core-side initiator: turns a one-cycle access command into an arbiter request,
// holds it until granted, then waits out the RAM read latency and returns data.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter logic [7:0] CORE_ID  = 8'd0,
    parameter int         AW       = 8,
    parameter int         DW       = 8,
    parameter int         READ_LAT = 1
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [3:0]    Mem_Ctrl,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] Dout,
    input  logic [DW-1:0] Din,
    input  logic          acq,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          busy,
    output logic [7:0]    stall_cnt,
    output logic [7:0]    dbg_id
);

    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       accept;
    logic       stall_en;

    // FIN accepts a new command too, so back-to-back accesses keep busy high.
    assign accept   = start && ((state == MRQ_IDLE) || (state == MRQ_FIN));
    assign stall_en = (state == MRQ_REQ) && !acq;
    assign done     = (state == MRQ_FIN);
    assign busy     = (state != MRQ_IDLE);
    assign dbg_id   = CORE_ID;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= MRQ_IDLE;
            lat_cnt  <= '0;
            Mem_Ctrl <= '0;
            Address  <= '0;
            Dout     <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                MRQ_IDLE, MRQ_FIN: begin
                    if (accept) begin
                        Address  <= addr;
                        Dout     <= wdata;
                        Mem_Ctrl <= mc_encode(we);
                        state    <= MRQ_REQ;
                    end else begin
                        state    <= MRQ_IDLE;
                    end
                end
                MRQ_REQ: begin
                    if (acq) begin
                        Mem_Ctrl <= '0;
                        if (Mem_Ctrl[MC_WREN]) begin
                            state <= MRQ_FIN;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= MRQ_RDWAIT;
                        end
                    end
                end
                MRQ_RDWAIT: begin
                    // RAMq holds the data in the cycle the counter reaches zero.
                    if (lat_cnt == 2'd0) begin
                        rdata <= Din;
                        state <= MRQ_FIN;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: state <= MRQ_IDLE;
            endcase
        end
    end

    sat_counter #(.W(8)) u_stall (
        .CLK   (CLK),
        .rst   (rst),
        .clr   (accept),
        .en    (stall_en),
        .count (stall_cnt)
    );

endmodule
